vga_agc_ctrl: RTL and testbench
===============================

# vga_agc_ctrl

Automatic gain control sequencer for the analog front-end VGA. It consumes the unsigned 8-bit SAR ADC result stream (one `adc_valid` pulse per finished conversion) and measures peak signal magnitude over fixed windows of samples. At each window boundary it steps the 3-bit VGA gain code up or down, then discards a settling period of samples before the next measurement. It sits between the ADC readout and the VGA thermometer decoder, and replaces open-loop level detection with a windowed, hysteretic closed loop.

## Interface
- `WINDOW`, 64: valid samples per measurement window (≥2).
- `SETTLE_N`, 4: valid samples discarded after a gain change or enable (0 = none).
- `HI_THR`, 112: peak magnitude at or above which gain steps down.
- `LO_THR`, 48: peak magnitude below which gain steps up. Must satisfy `LO_THR < HI_THR`.
- `INIT_GAIN`, 4: gain code after reset.
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: loop enable (level).
- `adc_data` in 8: unsigned offset-binary ADC result; midscale is 128.
- `adc_valid` in 1: one-cycle pulse; `adc_data` is valid in the same cycle.
- `gain_code` out 3: VGA gain code; 0 = minimum gain, 7 = maximum.
- `gain_update` out 1: one-cycle pulse in the first cycle a new `gain_code` is presented.
- `peak` out 7: peak magnitude of the last completed window.
- `locked` out 1: the last decision produced no change.

## Operation
- Magnitude: `mag = |adc_data − 128|`, range 0..128. A value of 128 (input 0) saturates to 127. The result is 7 bits unsigned.
- FSM states: IDLE, SETTLE, MEASURE, DECIDE.
- IDLE: counters are cleared. `en`=1 → SETTLE if `SETTLE_N>0`, else MEASURE.
- SETTLE: counts `adc_valid` pulses. On the `SETTLE_N`-th pulse → MEASURE. Settling samples never affect `acc`.
- MEASURE: on each `adc_valid`, `acc <= max(acc, mag)` and `cnt++`. On the `WINDOW`-th pulse, `peak <= max(acc, mag)`, `acc`/`cnt` clear, → DECIDE.
- DECIDE (exactly one cycle):
  - `peak ≥ HI_THR` and `gain_code>0`: decrement the gain code.
  - `peak < LO_THR` and `gain_code<7`: increment the gain code.
  - Otherwise: no change.
  - On a change: `gain_update`=1 next cycle, `locked<=0`, → SETTLE (or MEASURE if `SETTLE_N=0`).
  - On no change, including a requested step blocked at the rail: `locked<=1`, no pulse, → MEASURE.
- `adc_valid` in DECIDE or IDLE is dropped and counts toward nothing.
- `en` deasserting in any state → IDLE on the next edge.
  - `acc`, `cnt`, and the settle counter clear. `locked<=0`.
  - `gain_code` and `peak` hold.
  - A DECIDE cycle interrupted by `en`=0 makes no gain change.
- `gain_code` changes by at most ±1 per decision and never wraps below 0 or above 7.

## Timing
- Reset values: `gain_code=INIT_GAIN`, `gain_update=0`, `peak=0`, `locked=0`, state IDLE, all counters 0.
- All outputs are registered.
- Edge E0 samples the final window `adc_valid`: `peak` updates and the state becomes DECIDE.
- Edge E1: `gain_code` and `locked` update, and `gain_update` is high for the cycle E1→E2. Latency from the final `adc_valid` to the new `gain_code` is therefore 2 clocks.
- The first counted settle or measure sample is the first `adc_valid` strictly after the E1 edge.
- `adc_valid` pulses closer than 3 cycles apart are not supported. The ADC conversion time is ≥9 cycles.
- When `en` rises, the state leaves IDLE at the first edge where `en`=1 is sampled.

## Test plan
- Reset with `en`=0: `gain_code`=4, `peak`=0, `locked`=0, `gain_update`=0. Applying `adc_valid` with `en`=0 causes no change.
- `en`=1, 4 settle samples, then 64 samples alternating 100/156 (peak 28): `peak`=28, `gain_code` 4→5, and `gain_update` pulses once 2 clocks after the 64th `adc_valid`. The next 4 samples are ignored.
- 64 samples containing one 0 and the rest 128: `peak`=127 (saturated), gain steps down by 1. One 240 sample (mag 112 = `HI_THR`) also steps down.
- Hold peak at 20 for repeated windows starting at gain 7: gain stays 7, no `gain_update`, and `locked`=1 after each decision. At gain 0 with peak 127, gain stays 0.
- Peak 80 (inside the hysteresis band): no change and `locked`=1. Then peak 20: gain +1 and `locked`=0.
- Drop `en` after 30 window samples, then re-enable: the state passes through SETTLE, the next window requires a full 64 fresh samples, and `gain_code` is unchanged across the interruption. Asserting `rst` mid-MEASURE restores all reset values immediately.

Source files
------------

// File: rtl/vga_agc_ctrl.sv
// vga_agc_ctrl: windowed peak-detect AGC sequencer for the front-end VGA.
// Measures peak |adc_data - 128| over WINDOW valid samples, steps the 3-bit
// gain code by at most one per window with LO/HI hysteresis, and discards
// SETTLE_N samples after every gain change or (re-)enable.
module vga_agc_ctrl #(
  parameter int WINDOW    = 64,
  parameter int SETTLE_N  = 4,
  parameter int HI_THR    = 112,
  parameter int LO_THR    = 48,
  parameter int INIT_GAIN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] adc_data,
  input  logic       adc_valid,
  output logic [2:0] gain_code,
  output logic       gain_update,
  output logic [6:0] peak,
  output logic       locked
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DECIDE  = 2'd3
  } state_t;

  localparam int CW = $clog2(WINDOW);
  localparam int SW = (SETTLE_N > 1) ? $clog2(SETTLE_N) : 1;
  localparam logic [CW-1:0] CNT_LAST    = CW'(WINDOW - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_N > 0) ? (SETTLE_N - 1) : 0);
  localparam logic [7:0]    HI_T        = 8'(HI_THR);
  localparam logic [7:0]    LO_T        = 8'(LO_THR);
  localparam logic [2:0]    GAIN_RST    = 3'(INIT_GAIN);
  // After enable or a gain step the loop settles first unless settling is disabled.
  localparam state_t        AFTER_START = (SETTLE_N > 0) ? SETTLE : MEASURE;

  // Offset-binary to magnitude; input 0 (distance 128) clips to 127.
  function automatic logic [6:0] calc_mag(input logic [7:0] d);
    logic [7:0] m;
    if (d[7]) begin
      m = d - 8'd128;
    end else begin
      m = 8'd128 - d;
    end
    if (m[7]) begin
      calc_mag = 7'd127;
    end else begin
      calc_mag = m[6:0];
    end
  endfunction

  state_t        state_r, state_s;
  logic [6:0]    acc_r, acc_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [SW-1:0] settle_cnt_r, settle_cnt_s;
  logic [6:0]    peak_r, peak_s;
  logic [2:0]    gain_r, gain_s;
  logic          gain_update_r, gain_update_s;
  logic          locked_r, locked_s;
  logic [6:0]    mag_s;
  logic [6:0]    max_s;

  assign mag_s = calc_mag(adc_data);
  assign max_s = (mag_s > acc_r) ? mag_s : acc_r;

  // Next-state and next-output logic for the settle/measure/decide loop.
  always_comb begin
    state_s       = state_r;
    acc_s         = acc_r;
    cnt_s         = cnt_r;
    settle_cnt_s  = settle_cnt_r;
    peak_s        = peak_r;
    gain_s        = gain_r;
    gain_update_s = 1'b0;
    locked_s      = locked_r;
    if (!en) begin
      // Disable aborts any phase (including DECIDE) without touching gain or peak.
      state_s      = IDLE;
      acc_s        = 7'd0;
      cnt_s        = '0;
      settle_cnt_s = '0;
      locked_s     = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          acc_s        = 7'd0;
          cnt_s        = '0;
          settle_cnt_s = '0;
          state_s      = AFTER_START;
        end
        SETTLE: begin
          if (adc_valid) begin
            if (settle_cnt_r == SETTLE_LAST) begin
              settle_cnt_s = '0;
              state_s      = MEASURE;
            end else begin
              settle_cnt_s = settle_cnt_r + 1'b1;
            end
          end else begin
            settle_cnt_s = settle_cnt_r;
          end
        end
        MEASURE: begin
          if (adc_valid) begin
            if (cnt_r == CNT_LAST) begin
              peak_s  = max_s;
              acc_s   = 7'd0;
              cnt_s   = '0;
              state_s = DECIDE;
            end else begin
              acc_s = max_s;
              cnt_s = cnt_r + 1'b1;
            end
          end else begin
            acc_s = acc_r;
          end
        end
        DECIDE: begin
          if (({1'b0, peak_r} >= HI_T) && (gain_r != 3'd0)) begin
            gain_s        = gain_r - 3'd1;
            gain_update_s = 1'b1;
            locked_s      = 1'b0;
            state_s       = AFTER_START;
          end else if (({1'b0, peak_r} < LO_T) && (gain_r != 3'd7)) begin
            gain_s        = gain_r + 3'd1;
            gain_update_s = 1'b1;
            locked_s      = 1'b0;
            state_s       = AFTER_START;
          end else begin
            locked_s = 1'b1;
            state_s  = MEASURE;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      acc_r         <= 7'd0;
      cnt_r         <= '0;
      settle_cnt_r  <= '0;
      peak_r        <= 7'd0;
      gain_r        <= GAIN_RST;
      gain_update_r <= 1'b0;
      locked_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      acc_r         <= acc_s;
      cnt_r         <= cnt_s;
      settle_cnt_r  <= settle_cnt_s;
      peak_r        <= peak_s;
      gain_r        <= gain_s;
      gain_update_r <= gain_update_s;
      locked_r      <= locked_s;
    end
  end

  assign gain_code   = gain_r;
  assign gain_update = gain_update_r;
  assign peak        = peak_r;
  assign locked      = locked_r;

endmodule

// File: tb/tb_vga_agc_ctrl.sv
// tb_vga_agc_ctrl: scoreboard bench for vga_agc_ctrl. A window-level
// reference model predicts each decision when the final window sample is
// issued; a monitor compares the DUT outputs on the cycle they are due and
// checks gain_code/gain_update stay quiet on every other cycle.
module tb_vga_agc_ctrl;

  localparam int WINDOW    = 64;
  localparam int SETTLE_N  = 4;
  localparam int HI_THR    = 112;
  localparam int LO_THR    = 48;
  localparam int INIT_GAIN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] adc_data = 8'd128;
  logic       adc_valid = 1'b0;
  logic [2:0] gain_code;
  logic       gain_update;
  logic [6:0] peak;
  logic       locked;

  vga_agc_ctrl #(
    .WINDOW(WINDOW), .SETTLE_N(SETTLE_N), .HI_THR(HI_THR),
    .LO_THR(LO_THR), .INIT_GAIN(INIT_GAIN)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .adc_data(adc_data), .adc_valid(adc_valid),
    .gain_code(gain_code), .gain_update(gain_update), .peak(peak), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int pk;
    int g;
    int lk;
    int upd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   cur_gain = INIT_GAIN;

  // Reference model state (stimulus side).
  bit   m_en = 1'b0;
  int   m_gain = INIT_GAIN;
  int   settle_left = 0;
  int   win[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  function automatic int mag_of(input int d);
    int m;
    m = d - 128;
    if (m < 0) m = -m;
    if (m > 127) m = 127;
    return m;
  endfunction

  // Monitor: compares scheduled decisions and checks quiet cycles.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      cur_gain = INIT_GAIN;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        chk("decision_missed", cyc, e.due);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        cur_gain = e.g;
        chk("peak", int'(peak), e.pk);
        chk("locked", int'(locked), e.lk);
        chk("gain_update", int'(gain_update), e.upd);
      end else begin
        chk("no_spurious_update", int'(gain_update), 0);
      end
      chk("gain_code", int'(gain_code), cur_gain);
    end
  end

  task automatic model_disable();
    m_en = 1'b0;
    settle_left = 0;
    win.delete();
  endtask

  task automatic send_sample(input int d);
    exp_t e;
    int pk;
    int old;
    @(negedge clk);
    adc_data  = 8'(d);
    adc_valid = 1'b1;
    if (m_en) begin
      if (settle_left > 0) begin
        settle_left--;
      end else begin
        win.push_back(mag_of(d));
        if (win.size() == WINDOW) begin
          pk = 0;
          foreach (win[i]) if (win[i] > pk) pk = win[i];
          win.delete();
          old = m_gain;
          if (pk >= HI_THR && m_gain > 0) m_gain = m_gain - 1;
          else if (pk < LO_THR && m_gain < 7) m_gain = m_gain + 1;
          e.due = cyc + 2;
          e.pk  = pk;
          e.g   = m_gain;
          e.upd = (m_gain != old) ? 1 : 0;
          e.lk  = (m_gain != old) ? 0 : 1;
          exp_q.push_back(e);
          if (m_gain != old) settle_left = SETTLE_N;
        end
      end
    end
    @(negedge clk);
    adc_valid = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  task automatic enable_loop();
    @(negedge clk);
    en = 1'b1;
    m_en = 1'b1;
    settle_left = SETTLE_N;
    win.delete();
    repeat (2) @(negedge clk);
  endtask

  // Sample whose magnitude is exactly amp (amp 128 means input 0).
  function automatic int exact_sample(input int amp, input bit pos);
    if (amp >= 128) return 0;
    return pos ? 128 + amp : 128 - amp;
  endfunction

  // mode 0: random fill with |m|<=amp; mode 1: flat midscale; mode 2: alternate +/-amp.
  task automatic run_window(input int amp, input int mode);
    int p;
    int m;
    int d;
    while (settle_left > 0) send_sample($urandom_range(0, 255));
    p = $urandom_range(0, WINDOW - 1);
    for (int i = 0; i < WINDOW; i++) begin
      if (mode == 2) begin
        d = (i % 2 == 0) ? 128 - amp : 128 + amp;
      end else if (i == p) begin
        d = exact_sample(amp, (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1)));
      end else if (mode == 1) begin
        d = 128;
      end else begin
        m = $urandom_range(0, (amp > 127) ? 127 : amp);
        d = $urandom_range(0, 1) ? 128 + m : 128 - m;
        if (amp >= 128 && $urandom_range(0, 7) == 0) d = 0;
      end
      send_sample(d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_gain", int'(gain_code), INIT_GAIN);
    chk("rst_peak", int'(peak), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_update", int'(gain_update), 0);

    // Samples while disabled are ignored.
    for (int i = 0; i < 3; i++) send_sample(0);
    chk("disabled_peak", int'(peak), 0);
    chk("disabled_locked", int'(locked), 0);

    enable_loop();
    run_window(28, 2);            // peak 28 -> gain 5
    run_window(128, 1);           // saturated 127 -> gain 4
    run_window(112, 1);           // 240 sample at HI_THR -> gain 3
    for (int i = 0; i < 6; i++) run_window(20, 0);   // up to 7, then held at rail
    for (int i = 0; i < 8; i++) run_window(128, 0);  // down to 0, then held at rail
    run_window(80, 0);            // inside band: locked
    run_window(20, 0);            // gain 0 -> 1, unlocked
    run_window(111, 1);           // just below HI_THR: no change
    run_window(48, 0);            // at LO_THR: no change
    run_window(47, 0);            // just below LO_THR: up

    // Interrupt mid-window, then re-enable: a full fresh window is needed.
    drain();
    while (settle_left > 0) send_sample($urandom_range(0, 255));
    for (int i = 0; i < 30; i++) send_sample($urandom_range(0, 255));
    @(negedge clk);
    en = 1'b0;
    model_disable();
    @(negedge clk);
    chk("disable_locked", int'(locked), 0);
    for (int i = 0; i < 2; i++) send_sample(0);
    enable_loop();
    run_window(10, 0);

    for (int i = 0; i < 4; i++) run_window($urandom_range(0, 128), 0);

    // Asynchronous reset in the middle of a measurement window.
    drain();
    while (settle_left > 0) send_sample($urandom_range(0, 255));
    for (int i = 0; i < 20; i++) send_sample($urandom_range(0, 255));
    @(negedge clk);
    #2;
    rst = 1'b1;
    en  = 1'b0;
    model_disable();
    m_gain = INIT_GAIN;
    #1;
    chk("midrst_gain", int'(gain_code), INIT_GAIN);
    chk("midrst_peak", int'(peak), 0);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_update", int'(gain_update), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
